// File: rtl/cnn_layer_accel_awe_weight_loader.sv
// rtl/cnn_layer_accel_awe_weight_loader.sv - streams one layer's weights into the distributor, upper half then lower half
// Optional running checksum of written words: define AWE_WEIGHT_LOADER_CHECKSUM_EN.
// Parameter defaults mirror the values in cnn_layer_accel_defs.vh.
module cnn_layer_accel_awe_weight_loader #(
  parameter int C_WEIGHT_WIDTH = 8,
  parameter int C_PACKET_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  cfg_no_of_kernals,
  input  logic [3:0]                  cfg_size_of_kernal,
  input  logic [7:0]                  cfg_input_map_size,
  input  logic                        weight_in_valid,
  output logic                        weight_in_ready,
  input  logic [2*C_WEIGHT_WIDTH-1:0] weight_in_data,
  output logic                        config_valid,
  output logic [C_PACKET_WIDTH-1:0]   config_packet,
  output logic                        write_weights_valid,
  output logic [2*C_WEIGHT_WIDTH-1:0] weight_input,
  output logic                        busy,
  output logic                        done,
  output logic [2*C_WEIGHT_WIDTH-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    FILL_UPPER,
    GAP,
    FILL_LOWER,
    DONE
  } state_t;

  state_t     state;
  logic [8:0] word_count;
  logic [8:0] words_per_half;
  logic       last_word;

  // Ready is registered and only high in the fill states, so a handshake implies a fill state.
  assign last_word = (word_count == words_per_half - 9'd1);

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      word_count          <= '0;
      words_per_half      <= '0;
      weight_in_ready     <= 1'b0;
      config_valid        <= 1'b0;
      config_packet       <= '0;
      write_weights_valid <= 1'b0;
      weight_input        <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
`ifdef AWE_WEIGHT_LOADER_CHECKSUM_EN
      checksum            <= '0;
`endif
    end else begin
      config_valid        <= 1'b0;
      write_weights_valid <= 1'b0;
      done                <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state                <= CONFIG;
            busy                 <= 1'b1;
            config_valid         <= 1'b1;
            config_packet        <= '0;
            config_packet[15:0]  <= {cfg_input_map_size, cfg_size_of_kernal, cfg_no_of_kernals};
            words_per_half       <= 9'(({5'd0, cfg_no_of_kernals} + 9'd1) *
                                       ({5'd0, cfg_size_of_kernal} + 9'd1));
            word_count           <= '0;
`ifdef AWE_WEIGHT_LOADER_CHECKSUM_EN
            checksum             <= '0;
`endif
          end
        end
        CONFIG: begin
          state           <= FILL_UPPER;
          weight_in_ready <= 1'b1;
        end
        FILL_UPPER, FILL_LOWER: begin
          if (weight_in_valid) begin
            write_weights_valid <= 1'b1;
            weight_input        <= weight_in_data;
`ifdef AWE_WEIGHT_LOADER_CHECKSUM_EN
            checksum            <= checksum + weight_in_data;
`endif
            if (last_word) begin
              word_count      <= '0;
              weight_in_ready <= 1'b0;
              if (state == FILL_UPPER) begin
                state <= GAP;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              word_count <= word_count + 9'd1;
            end
          end
        end
        GAP: begin
          state           <= FILL_LOWER;
          weight_in_ready <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          busy            <= 1'b0;
          weight_in_ready <= 1'b0;
        end
      endcase
    end
  end

`ifndef AWE_WEIGHT_LOADER_CHECKSUM_EN
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_awe_weight_loader.sv
// tb/tb_cnn_layer_accel_awe_weight_loader.sv - directed self-checking bench for the weight loader
module tb_cnn_layer_accel_awe_weight_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cfg_no_of_kernals = '0;
  logic [3:0]  cfg_size_of_kernal = '0;
  logic [7:0]  cfg_input_map_size = '0;
  logic        weight_in_valid = 1'b0;
  logic        weight_in_ready;
  logic [15:0] weight_in_data = '0;
  logic        config_valid;
  logic [31:0] config_packet;
  logic        write_weights_valid;
  logic [15:0] weight_input;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  int checks = 0;
  int errors = 0;

  int          wr_cyc[$];
  logic [15:0] wr_data[$];
  int          hs_cyc[$];
  int          cfg_cnt;
  logic [31:0] pkt;
  int          done_cnt;
  int          done_cyc;
  logic        busy_after;

  cnn_layer_accel_awe_weight_loader #(
    .C_WEIGHT_WIDTH(8),
    .C_PACKET_WIDTH(32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .cfg_no_of_kernals   (cfg_no_of_kernals),
    .cfg_size_of_kernal  (cfg_size_of_kernal),
    .cfg_input_map_size  (cfg_input_map_size),
    .weight_in_valid     (weight_in_valid),
    .weight_in_ready     (weight_in_ready),
    .weight_in_data      (weight_in_data),
    .config_valid        (config_valid),
    .config_packet       (config_packet),
    .write_weights_valid (write_weights_valid),
    .weight_input        (weight_input),
    .busy                (busy),
    .done                (done),
    .checksum            (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cfg_valid"}, 32'(config_valid), 32'd0);
    check({tag, "_cfg_pkt"}, config_packet, 32'd0);
    check({tag, "_wr_valid"}, 32'(write_weights_valid), 32'd0);
    check({tag, "_wr_data"}, 32'(weight_input), 32'd0);
    check({tag, "_ready"}, 32'(weight_in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  // Runs one load; data is fixed_data if nonzero, else 16'h1000 + word index.
  task automatic run_load(input logic [3:0] n, input logic [3:0] k, input logic [7:0] m,
                          input bit toggle, input int abort_after, input int poke_at,
                          input logic [15:0] fixed_data);
    int  sent;
    bit  hs;
    bit  poked;
    wr_cyc.delete();
    wr_data.delete();
    hs_cyc.delete();
    cfg_cnt = 0;
    pkt = '0;
    done_cnt = 0;
    done_cyc = -1;
    busy_after = 1'b1;
    sent = 0;
    poked = 1'b0;
    cfg_no_of_kernals = n;
    cfg_size_of_kernal = k;
    cfg_input_map_size = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 400; c++) begin
      if (config_valid) begin cfg_cnt++; pkt = config_packet; end
      if (write_weights_valid) begin wr_cyc.push_back(c); wr_data.push_back(weight_input); end
      if (done) begin done_cnt++; done_cyc = c; end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
      if (abort_after > 0 && wr_data.size() == abort_after) begin
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midload_rst");
        weight_in_valid = 1'b0;
        #1;
        rst = 1'b0;
        return;
      end
      if (poke_at > 0 && wr_data.size() == poke_at && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      weight_in_valid = toggle ? (c % 2 == 1) : 1'b1;
      weight_in_data = (fixed_data != 16'd0) ? fixed_data : 16'(16'h1000 + sent);
      hs = weight_in_valid && weight_in_ready;
      @(posedge clk);
      #1;
      if (hs) begin hs_cyc.push_back(c + 1); sent++; end
    end
    weight_in_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // N=1,K=2,M=5 continuous valid
    run_load(4'd1, 4'd2, 8'd5, 1'b0, 0, 0, 16'd0);
    check("A_cfg_count", 32'(cfg_cnt), 32'd1);
    check("A_pkt", pkt, 32'h0000_0521);
    check("A_writes", 32'(wr_data.size()), 32'd12);
    check("A_done_count", 32'(done_cnt), 32'd1);
    if (wr_data.size() == 12) begin
      check("A_upper_contig", 32'(wr_cyc[5] - wr_cyc[0]), 32'd5);
      check("A_gap", 32'(wr_cyc[6] - wr_cyc[5]), 32'd2);
      check("A_lower_contig", 32'(wr_cyc[11] - wr_cyc[6]), 32'd5);
      check("A_done_at_last", 32'(done_cyc), 32'(wr_cyc[11]));
      for (int i = 0; i < 12; i++) check("A_data", 32'(wr_data[i]), 32'(16'h1000 + i));
    end
    check("A_busy_after", 32'(busy_after), 32'd0);

    // N=0,K=0: one word per half with one gap cycle
    run_load(4'd0, 4'd0, 8'd3, 1'b0, 0, 0, 16'd0);
    check("B_writes", 32'(wr_data.size()), 32'd2);
    if (wr_data.size() == 2) check("B_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);
    check("B_done_count", 32'(done_cnt), 32'd1);

    // Toggling valid, N=0,K=1
    run_load(4'd0, 4'd1, 8'd7, 1'b1, 0, 0, 16'd0);
    check("C_writes", 32'(wr_data.size()), 32'd4);
    check("C_hs", 32'(hs_cyc.size()), 32'd4);
    if (wr_data.size() == 4 && hs_cyc.size() == 4)
      for (int i = 0; i < 4; i++) check("C_write_after_hs", 32'(wr_cyc[i]), 32'(hs_cyc[i]));
    check("C_done_count", 32'(done_cnt), 32'd1);

    // Reset after third upper write, then a fresh full load
    run_load(4'd1, 4'd2, 8'd5, 1'b0, 3, 0, 16'd0);
    @(posedge clk);
    #1;
    check("D_idle_busy", 32'(busy), 32'd0);
    run_load(4'd1, 4'd2, 8'd5, 1'b0, 0, 0, 16'd0);
    check("D_cfg_count", 32'(cfg_cnt), 32'd1);
    check("D_writes", 32'(wr_data.size()), 32'd12);
    if (wr_data.size() == 12) check("D_last_data", 32'(wr_data[11]), 32'h0000_100B);
    check("D_done_count", 32'(done_cnt), 32'd1);

    // Start pulsed during FILL_LOWER is ignored
    run_load(4'd1, 4'd1, 8'd9, 1'b0, 0, 5, 16'd0);
    check("E_cfg_count", 32'(cfg_cnt), 32'd1);
    check("E_writes", 32'(wr_data.size()), 32'd8);
    check("E_done_count", 32'(done_cnt), 32'd1);
    @(posedge clk);
    #1;
    check("E_no_restart", 32'(busy), 32'd0);

    // Eight words of FFFF
    run_load(4'd0, 4'd3, 8'd1, 1'b0, 0, 0, 16'hFFFF);
    check("F_writes", 32'(wr_data.size()), 32'd8);
`ifdef AWE_WEIGHT_LOADER_CHECKSUM_EN
    check("F_checksum", 32'(checksum), 32'h0000_FFF8);
`else
    check("F_checksum", 32'(checksum), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_awe_weight_loader.md
CNN_LAYER_ACCEL_AWE_WEIGHT_LOADER -- requirements
Module: cnn_layer_accel_awe_weight_loader

Interface
REQ-001 Parameters SHALL be: C_WEIGHT_WIDTH, default from cnn_layer_accel_defs.vh, width of one weight; C_PACKET_WIDTH, default from cnn_layer_accel_defs.vh, config packet width.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port clk SHALL be an input of width 1 and the sole clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be an input of width 1: asynchronous, active-high reset.
REQ-005 Port start SHALL be an input of width 1: single-cycle request to begin a load.
REQ-006 Ports cfg_no_of_kernals (input, 4), cfg_size_of_kernal (input, 4) and cfg_input_map_size (input, 8) SHALL carry layer parameters, all sampled when start is accepted.
REQ-007 Ports weight_in_valid (input, 1), weight_in_ready (output, 1) and weight_in_data (input, 2*C_WEIGHT_WIDTH) SHALL form the upstream weight stream.
REQ-008 Ports config_valid (output, 1) and config_packet (output, C_PACKET_WIDTH) SHALL drive the distributor configuration.
REQ-009 Ports write_weights_valid (output, 1) and weight_input (output, 2*C_WEIGHT_WIDTH) SHALL drive distributor weight writes.
REQ-010 Ports busy (output, 1), done (output, 1) and checksum (output, 2*C_WEIGHT_WIDTH) SHALL carry status.

Function
REQ-011 The FSM SHALL have the states IDLE, CONFIG, FILL_UPPER, GAP, FILL_LOWER and DONE.
REQ-012 In IDLE, start=1 SHALL latch the cfg_* inputs and move to CONFIG; start is ignored in every other state.
REQ-013 CONFIG SHALL last exactly 1 cycle, with config_valid=1 and config_packet[3:0]=no_of_kernals, [7:4]=size_of_kernal, [15:8]=input_map_size and all upper bits 0; next state FILL_UPPER.
REQ-014 weight_in_ready SHALL be 1 only in FILL_UPPER and FILL_LOWER, and SHALL be 0 in every other state.
REQ-015 A handshake (valid&ready) SHALL produce write_weights_valid=1 with weight_input=weight_in_data on the next cycle; with no handshake, write_weights_valid=0 and weight_input holds its previous value.
REQ-016 Words per half SHALL be (no_of_kernals+1)*(size_of_kernal+1), counted by a 9-bit counter (max 256, no overflow).
REQ-017 On the last upper-half handshake the FSM SHALL go to GAP, hold there 1 cycle with ready=0, then enter FILL_LOWER, guaranteeing a write-free cycle while the distributor switches halves.
REQ-018 On the last lower-half handshake the FSM SHALL go to DONE; DONE SHALL pulse done=1 for 1 cycle and then return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 Upstream stalls (valid=0) SHALL hold the counter and state with no timeout.
REQ-021 cfg size 0/0 SHALL load exactly 1 word per half.

Reset
REQ-022 Asserting rst at any time, including mid-load, SHALL force IDLE and clear counters immediately.
REQ-023 While rst is asserted, config_valid, config_packet, write_weights_valid, weight_input, weight_in_ready, busy, done and checksum SHALL all be 0.
REQ-024 Words in flight at reset SHALL be discarded, and a later start SHALL begin a fresh load.

Configuration
REQ-025 With the macro AWE_WEIGHT_LOADER_CHECKSUM_EN defined, checksum SHALL hold the modulo-2^(2*C_WEIGHT_WIDTH) sum of all words written in the current load, cleared in CONFIG and held after DONE until the next start.
REQ-026 With AWE_WEIGHT_LOADER_CHECKSUM_EN undefined, checksum SHALL be tied to 0 and no adder logic SHALL exist.

Verification
REQ-027 A bench SHALL cover: cfg N=1,K=2,M=5 with continuous valid -> one config_valid with packet[15:0]=16'h0521, then 6 writes, 1 idle cycle, 6 writes, then done after the last write.
REQ-028 A bench SHALL cover: cfg N=0,K=0 -> exactly 2 writes with one gap cycle between them.
REQ-029 A bench SHALL cover: upstream valid toggling 1,0,1,0 -> writes appear only 1 cycle after each handshake and counts still total 2*(N+1)*(K+1).
REQ-030 A bench SHALL cover: rst asserted after the 3rd upper write -> all outputs 0 asynchronously; a new start gives a full, correct load.
REQ-031 A bench SHALL cover: start pulsed during FILL_LOWER -> no effect, config_valid not reasserted.
REQ-032 A bench SHALL cover, with CHECKSUM_EN and 8 words of value 16'hFFFF -> checksum=16'hFFF8.
